// File: rtl/output_buffer.sv
// Output deskew buffer: realigns column-skewed array results into whole rows
// and queues them in a small FIFO drained by the downstream consumer.
module output_buffer #(
  parameter int ARRAYWIDTH = 4,
  parameter int DATASIZE   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [ARRAYWIDTH*DATASIZE-1:0]   in_psum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAYWIDTH*DATASIZE-1:0]   out_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             full,
  output logic                             empty,
  output logic                             overflow,
  input  logic                             ovf_clr
);

  localparam int W   = ARRAYWIDTH * DATASIZE;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int LAT = ARRAYWIDTH - 1;

  logic [W-1:0] aligned;
  logic         wr_valid;

  // Lane i waits ARRAYWIDTH-1-i cycles so every lane meets the last one.
  for (genvar gi = 0; gi < ARRAYWIDTH; gi++) begin : g_lane
    localparam int D = ARRAYWIDTH - 1 - gi;
    if (D == 0) begin : g_wire
      assign aligned[gi*DATASIZE +: DATASIZE] = in_psum[gi*DATASIZE +: DATASIZE];
    end else begin : g_dly
      logic [DATASIZE-1:0] dl_q [D];
      logic [DATASIZE-1:0] dl_d [D];

      always_comb begin
        dl_d[0] = in_psum[gi*DATASIZE +: DATASIZE];
        for (int k = 1; k < D; k++) dl_d[k] = dl_q[k-1];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < D; k++) dl_q[k] <= '0;
        end else begin
          dl_q <= dl_d;
        end
      end

      assign aligned[gi*DATASIZE +: DATASIZE] = dl_q[D-1];
    end
  end

  if (LAT == 0) begin : g_vld_wire
    assign wr_valid = in_valid;
  end else begin : g_vld_pipe
    logic [LAT-1:0] vld_q, vld_d;

    always_comb vld_d = (vld_q << 1) | LAT'(in_valid);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_q <= '0;
      else      vld_q <= vld_d;
    end

    assign wr_valid = vld_q[LAT-1];
  end

  // Handshake: a row transfers on any edge where out_valid && out_ready;
  // out_valid is purely registered state and never looks at out_ready.
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_en, wr_en, drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    rd_en      = out_valid && out_ready;
    wr_en      = wr_valid && (!full || rd_en);
    drop       = wr_valid && full && !rd_en;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = aligned;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear must still be recorded.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: skewed row driver, expected-row queue
// checked on every transfer, and one task per scenario.
module tb_output_buffer;
  localparam int AW = 4;
  localparam int DS = 16;
  localparam int W  = AW * DS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_psum = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic         full, empty, overflow;
  logic         ovf_clr = 1'b0;

  int checks = 0;
  int fails  = 0;
  int n_reads = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] hrow [AW];
  bit           hv   [AW];

  output_buffer #(.ARRAYWIDTH(AW), .DATASIZE(DS), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: every transfer must match the oldest expected row
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      n_reads++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_row: got %h, required no transfer", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL sb_row_data: got %h, required %h", out_data, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] mk_row(input int r);
    logic [W-1:0] v;
    for (int i = 0; i < AW; i++) v[i*DS +: DS] = 16'(16 * r + i);
    return v;
  endfunction

  // One cycle of stimulus: lane i carries the row started i cycles ago.
  task automatic drive_cycle(input bit v, input logic [W-1:0] row, input bit rdy);
    for (int k = AW - 1; k > 0; k--) begin
      hrow[k] = hrow[k-1];
      hv[k]   = hv[k-1];
    end
    hrow[0]   = row;
    hv[0]     = v;
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < AW; i++)
      in_psum[i*DS +: DS] = hv[i] ? hrow[i][i*DS +: DS] : 16'hdead;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < AW; k++) begin hv[k] = 1'b0; hrow[k] = '0; end
    rst = 1'b0;
    repeat (3) drive_cycle(1'b0, '0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || full !== 1'b0 ||
        overflow !== 1'b0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_values: valid=%b empty=%b count=%0d full=%b ovf=%b data=%h, required 0 1 0 0 0 0",
               out_valid, empty, count, full, overflow, out_data);
    end
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 3'd0 || overflow !== 1'b0) begin
        fails++;
        $display("FAIL idle_cycle%0d: valid=%b empty=%b count=%0d ovf=%b, required 0 1 0 0",
                 c, out_valid, empty, count, overflow);
      end
    end
  endtask

  task automatic test_single_row();
    logic [W-1:0] row;
    row = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    exp_q.push_back(row);
    drive_cycle(1'b1, row, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL single_early_valid_t+%0d: got %b, required 0", k, out_valid);
      end
      drive_cycle(1'b0, '0, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== row || count !== 3'd1) begin
      fails++;
      $display("FAIL single_row_out: valid=%b data=%h count=%0d, required 1 %h 1",
               out_valid, out_data, count, row);
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL single_drain_empty: got %b, required 1", empty);
    end
  endtask

  task automatic test_streaming();
    int run = 0;
    int first = -1;
    int last = -1;
    int r0;
    r0 = n_reads;
    for (int k = 1; k <= 21; k++) begin
      if (k <= 16) begin
        exp_q.push_back(mk_row(k - 1));
        drive_cycle(1'b1, mk_row(k - 1), 1'b1);
      end else begin
        drive_cycle(1'b0, '0, 1'b1);
      end
      checks++;
      if (count > 3'd1) begin
        fails++;
        $display("FAIL stream_count_le1_k%0d: got %0d, required <=1", k, count);
      end
      if (out_valid) begin
        run++;
        if (first < 0) first = k;
        last = k;
      end
    end
    checks++;
    if (first != 4 || last != 19 || run != 16) begin
      fails++;
      $display("FAIL stream_continuous: first=%0d last=%0d run=%0d, required 4 19 16", first, last, run);
    end
    checks++;
    if (n_reads - r0 != 16) begin
      fails++;
      $display("FAIL stream_reads: got %0d, required 16", n_reads - r0);
    end
  endtask

  task automatic test_full_overflow();
    for (int k = 1; k <= 8; k++) begin
      if (k <= 5) begin
        if (k <= 4) exp_q.push_back(mk_row(100 + k));
        drive_cycle(1'b1, mk_row(100 + k), 1'b0);
      end else begin
        drive_cycle(1'b0, '0, 1'b0);
      end
      if (k == 7) begin
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
          fails++;
          $display("FAIL full_before_drop: full=%b count=%0d ovf=%b, required 1 4 0", full, count, overflow);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1 || out_data !== mk_row(101)) begin
      fails++;
      $display("FAIL overflow_drop: full=%b count=%0d ovf=%b head=%h, required 1 4 1 %h",
               full, count, overflow, out_data, mk_row(101));
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL drain_after_ovf: empty=%b ovf=%b, required 1 1", empty, overflow);
    end
    ovf_clr = 1'b1;
    drive_cycle(1'b0, '0, 1'b0);
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b, required 0", overflow);
    end
  endtask

  task automatic test_full_read();
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) begin
        exp_q.push_back(mk_row(200 + k));
        drive_cycle(1'b1, mk_row(200 + k), 1'b0);
      end else begin
        drive_cycle(1'b0, '0, 1'b0);
      end
    end
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      fails++;
      $display("FAIL fr_prefill: full=%b count=%0d, required 1 4", full, count);
    end
    exp_q.push_back(mk_row(299));
    drive_cycle(1'b1, mk_row(299), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || out_data !== mk_row(202)) begin
      fails++;
      $display("FAIL fr_accept: count=%0d full=%b ovf=%b head=%h, required 4 1 0 %h",
               count, full, overflow, out_data, mk_row(202));
    end
    repeat (3) drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (out_data !== mk_row(299) || count !== 3'd1) begin
      fails++;
      $display("FAIL fr_new_row_4th: head=%h count=%0d, required %h 1", out_data, count, mk_row(299));
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL fr_drain_empty: got %b, required 1", empty);
    end
  endtask

  task automatic test_reset_mid_row();
    int seen = 0;
    for (int c = 10; c <= 24; c++) begin
      if (c == 12) rst = 1'b0;
      if (c == 15) rst = 1'b1;
      if (c > 10 && c < 24 && out_valid) seen++;
      if (c == 10)      drive_cycle(1'b1, mk_row(300), 1'b0);
      else if (c == 20) drive_cycle(1'b1, mk_row(320), 1'b0);
      else if (c < 24)  drive_cycle(1'b0, '0, 1'b0);
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_reset_ghost: out_valid cycles=%0d, required 0", seen);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== mk_row(320) || count !== 3'd1) begin
      fails++;
      $display("FAIL mid_reset_row: valid=%b data=%h count=%0d, required 1 %h 1",
               out_valid, out_data, count, mk_row(320));
    end
    exp_q.push_back(mk_row(320));
    drive_cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_streaming();
    test_full_overflow();
    test_full_read();
    test_reset_mid_row();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rows_outstanding: got %0d, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
